// File: rtl/ppe_pkg.sv
// ppe_pkg: shared constants, opcodes and scheduler state encoding for the partial PE
package ppe_pkg;

    localparam int WEIGHT_WIDTH = 8;
    localparam int SUM_WIDTH    = 14;
    localparam int NUM_INPUTS   = 25;
    localparam int IMEM_ID      = 11;

    localparam logic [3:0] OP_WEIGHT        = 4'd0;
    localparam logic [3:0] OP_INPUT         = 4'd1;
    localparam logic [3:0] OP_TIMESTEP_DONE = 4'd2;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, IMEM} sched_state_t;

endpackage

// File: rtl/ppe_conv_scheduler_if.sv
// ppe_conv_scheduler_if: row, RF-read, partial-sum and IMEM handshakes of the convolution scheduler
interface ppe_conv_scheduler_if;

    logic                                     row_valid;
    logic                                     row_ready;
    logic                                     ts_done;
    logic                                     rf_req_valid;
    logic                                     rf_req_ready;
    logic [4:0]                               i_raddr;
    logic [2:0]                               w_raddr;
    logic                                     rf_rsp_valid;
    logic                                     i_rdata;
    logic signed [ppe_pkg::WEIGHT_WIDTH-1:0]  w_rdata;
    logic                                     ps_valid;
    logic                                     ps_ready;
    logic [3:0]                               ps_dest;
    logic [24:0]                              ps_data;
    logic                                     imem_valid;
    logic                                     imem_ready;
    logic [3:0]                               imem_dest;
    logic [3:0]                               imem_opcode;
    logic [1:0]                               ts;
    logic                                     busy;

    modport master (
        input  row_valid, ts_done, rf_req_ready, rf_rsp_valid, i_rdata, w_rdata, ps_ready, imem_ready,
        output row_ready, rf_req_valid, i_raddr, w_raddr, ps_valid, ps_dest, ps_data,
               imem_valid, imem_dest, imem_opcode, ts, busy
    );

    modport slave (
        output row_valid, ts_done, rf_req_ready, rf_rsp_valid, i_rdata, w_rdata, ps_ready, imem_ready,
        input  row_ready, rf_req_valid, i_raddr, w_raddr, ps_valid, ps_dest, ps_data,
               imem_valid, imem_dest, imem_opcode, ts, busy
    );

endinterface

// File: rtl/ppe_mac_acc.sv
// ppe_mac_acc: spike-gated signed weight accumulator, wrapping at SUM_WIDTH
module ppe_mac_acc #(
    parameter int SUM_WIDTH    = ppe_pkg::SUM_WIDTH,
    parameter int WEIGHT_WIDTH = ppe_pkg::WEIGHT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          en,
    input  logic                          spike,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    output logic signed [SUM_WIDTH-1:0]    acc
);

    // add the sign-extended weight only when the input spike is set
    always_ff @(posedge clk) begin
        if (reset || clr) acc <= '0;
        else if (en && spike) acc <= acc + SUM_WIDTH'(weight);
    end

endmodule

// File: rtl/ppe_conv_scheduler.sv
// ppe_conv_scheduler: sequences RF reads, window MACs, partial-sum sends and IMEM row requests
module ppe_conv_scheduler #(
    parameter int FILTER_SIZE = 5,
    parameter int IFMAP_SIZE  = 25,
    parameter int PE_ID       = 0,
    parameter int IMEM_ID     = ppe_pkg::IMEM_ID,
    parameter int ROWS_PER_TS = 441,
    parameter int SUM_WIDTH   = ppe_pkg::SUM_WIDTH
) (
    input logic                  clk,
    input logic                  reset,
    ppe_conv_scheduler_if.master bus
);

    import ppe_pkg::*;

    localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;

    sched_state_t               state;
    logic [4:0]                 win;
    logic [2:0]                 tap;
    logic [3:0]                 dest;
    logic [8:0]                 row_cnt;
    logic [8:0]                 row_base;
    logic                       pend_ts;
    logic [1:0]                 ts_inc;
    logic                       emit_leave;
    logic                       acc_clr;
    logic                       acc_en;
    logic signed [SUM_WIDTH-1:0] acc;

    // saturating timestep advance, row base after a same-cycle ts_done, and MAC control
    always_comb begin
        ts_inc     = bus.ts == 2'd3 ? 2'd3 : bus.ts + 2'd1;
        row_base   = bus.ts_done ? 9'd0 : row_cnt;
        emit_leave = state == EMIT && (!bus.ps_valid || bus.ps_ready);
        acc_clr    = (state == IDLE && bus.row_valid) || emit_leave;
        acc_en     = state == WAIT && bus.rf_rsp_valid;
    end

    assign bus.ps_data     = 25'(acc);
    assign bus.imem_dest   = 4'(IMEM_ID);
    assign bus.imem_opcode = 4'(PE_ID);

    ppe_mac_acc #(.SUM_WIDTH(SUM_WIDTH)) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (acc_en),
        .spike  (bus.i_rdata),
        .weight (bus.w_rdata),
        .acc    (acc)
    );

    // pass sequencer; every handshake output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bus.row_ready    <= 1'b1;
            bus.rf_req_valid <= 1'b0;
            bus.ps_valid     <= 1'b0;
            bus.imem_valid   <= 1'b0;
            bus.busy         <= 1'b0;
            bus.i_raddr      <= '0;
            bus.w_raddr      <= '0;
            bus.ps_dest      <= '0;
            bus.ts           <= 2'd1;
            win              <= '0;
            tap              <= '0;
            dest             <= '0;
            row_cnt          <= '0;
            pend_ts          <= 1'b0;
        end else begin
            if (bus.ts_done && state != IDLE) pend_ts <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.ts_done) begin
                        bus.ts  <= ts_inc;
                        row_cnt <= '0;
                    end
                    if (bus.row_valid) begin
                        row_cnt          <= row_base == 9'd511 ? row_base : row_base + 9'd1;
                        win              <= '0;
                        tap              <= '0;
                        bus.row_ready    <= 1'b0;
                        bus.busy         <= 1'b1;
                        bus.rf_req_valid <= 1'b1;
                        bus.i_raddr      <= '0;
                        bus.w_raddr      <= '0;
                        state            <= REQ;
                    end
                end
                REQ: if (bus.rf_req_ready) begin
                    bus.rf_req_valid <= 1'b0;
                    state            <= WAIT;
                end
                WAIT: if (bus.rf_rsp_valid) begin
                    if (tap == 3'(FILTER_SIZE - 1)) begin
                        bus.ps_valid <= row_cnt != 9'(ROWS_PER_TS);
                        bus.ps_dest  <= dest;
                        state        <= EMIT;
                    end else begin
                        tap              <= tap + 3'd1;
                        bus.rf_req_valid <= 1'b1;
                        bus.i_raddr      <= win + 5'(tap) + 5'd1;
                        bus.w_raddr      <= tap + 3'd1;
                        state            <= REQ;
                    end
                end
                EMIT: if (emit_leave) begin
                    bus.ps_valid <= 1'b0;
                    dest         <= dest == 4'(FILTER_SIZE - 1) ? 4'd0 : dest + 4'd1;
                    tap          <= '0;
                    if (win == 5'(OUTPUT_DIM - 1)) begin
                        bus.imem_valid <= 1'b1;
                        state          <= IMEM;
                    end else begin
                        win              <= win + 5'd1;
                        bus.rf_req_valid <= 1'b1;
                        bus.i_raddr      <= win + 5'd1;
                        bus.w_raddr      <= '0;
                        state            <= REQ;
                    end
                end
                IMEM: if (bus.imem_ready) begin
                    bus.imem_valid <= 1'b0;
                    bus.row_ready  <= 1'b1;
                    bus.busy       <= 1'b0;
                    pend_ts        <= 1'b0;
                    if (pend_ts || bus.ts_done) begin
                        bus.ts  <= ts_inc;
                        row_cnt <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppe_conv_scheduler.sv
// tb_ppe_conv_scheduler: randomized bench with RF/packetizer models and a window-sum reference
module tb_ppe_conv_scheduler;

    localparam int RP = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ppe_conv_scheduler_if bus();

    ppe_conv_scheduler #(.ROWS_PER_TS(RP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int imem_n = 0;
    bit stall = 1'b0;
    bit in_row [25];
    logic signed [7:0] wts [5];
    logic [28:0] got_q [$];
    logic [28:0] exp_q [$];
    int m_dest = 0;
    int m_row_cnt = 0;
    int m_ts = 1;
    logic [31:0] first_ps;
    int cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] ref_sum(input int w);
        int s;
        logic signed [13:0] r;
        s = 0;
        for (int t = 0; t < 5; t++) if (in_row[w + t]) s += int'(wts[t]);
        r = 14'(s);
        return 25'(r);
    endfunction

    // RF model: one outstanding read, answered after a random delay; stray rsp_valid when idle
    initial begin
        bit fire;
        bit pend;
        int ai;
        int aw;
        pend = 1'b0;
        ai = 0;
        aw = 0;
        bus.rf_req_ready = 1'b0;
        bus.rf_rsp_valid = 1'b0;
        bus.i_rdata = 1'b0;
        bus.w_rdata = '0;
        forever begin
            @(negedge clk);
            fire = !reset && bus.rf_req_valid && bus.rf_req_ready;
            if (fire) begin
                ai = int'(bus.i_raddr);
                aw = int'(bus.w_raddr);
            end
            @(posedge clk);
            #1;
            pend = !reset && (pend || fire);
            if (pend && (!stall || $urandom_range(2) != 0)) begin
                bus.rf_rsp_valid = 1'b1;
                bus.i_rdata = in_row[ai];
                bus.w_rdata = wts[aw];
                pend = 1'b0;
            end else begin
                bus.rf_rsp_valid = !pend && stall && $urandom_range(3) == 0;
                bus.i_rdata = 1'($urandom);
                bus.w_rdata = 8'($urandom);
            end
            bus.rf_req_ready = !stall || $urandom_range(1) == 1;
        end
    end

    // packetizer model: records transfers and checks payload stays put while stalled
    initial begin
        bit hold;
        logic [28:0] prev;
        logic [28:0] cur;
        hold = 1'b0;
        prev = '0;
        bus.ps_ready = 1'b0;
        bus.imem_ready = 1'b0;
        forever begin
            @(negedge clk);
            cur = {bus.ps_dest, bus.ps_data};
            if (reset || !bus.ps_valid) hold = 1'b0;
            else begin
                if (hold) chk("ps_hold", 32'(cur), 32'(prev));
                if (bus.ps_ready) begin
                    got_q.push_back(cur);
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    prev = cur;
                end
            end
            if (!reset && bus.imem_valid && bus.imem_ready) begin
                imem_n++;
                chk("imem_dest", 32'(bus.imem_dest), 32'd11);
                chk("imem_op", 32'(bus.imem_opcode), 32'd0);
            end
            @(posedge clk);
            #1;
            bus.ps_ready = !stall || $urandom_range(1) == 1;
            bus.imem_ready = !stall || $urandom_range(2) == 0;
        end
    end

    task automatic run_row(input int tsd_at, input bit tsd_with_row, output int cycles);
        int n0;
        int k;
        bit ok;
        bit sup;
        n0 = imem_n;
        if (tsd_with_row) begin
            m_ts = m_ts == 3 ? 3 : m_ts + 1;
            m_row_cnt = 0;
        end
        m_row_cnt = m_row_cnt == 511 ? 511 : m_row_cnt + 1;
        sup = m_row_cnt == RP;
        for (int w = 0; w < 21; w++) if (!sup) exp_q.push_back({4'((m_dest + w) % 5), ref_sum(w)});
        m_dest = (m_dest + 21) % 5;
        bus.row_valid = 1'b1;
        bus.ts_done = tsd_with_row;
        k = 0;
        ok = 1'b0;
        while (!ok && k < 50) begin
            @(negedge clk);
            ok = bus.row_ready;
            tick;
            bus.ts_done = 1'b0;
            k++;
        end
        bus.row_valid = 1'b0;
        chk("row_accept", 32'(ok), 32'd1);
        cycles = 0;
        while (imem_n == n0 && cycles < 20000) begin
            bus.ts_done = cycles == tsd_at;
            tick;
            cycles++;
            if (tsd_at >= 0 && cycles == tsd_at + 30 && imem_n == n0) chk("ts_mid", 32'(bus.ts), 32'(m_ts));
        end
        bus.ts_done = 1'b0;
        if (tsd_at >= 0) begin
            m_ts = m_ts == 3 ? 3 : m_ts + 1;
            m_row_cnt = 0;
        end
        chk("pass_done", 32'(imem_n - n0), 32'd1);
        chk("ts", 32'(bus.ts), 32'(m_ts));
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("ps_cnt", 32'(got_q.size()), 32'(exp_q.size()));
        first_ps = got_q.size() > 0 ? 32'(got_q[0][24:0]) : 32'hFFFF_FFFF;
        foreach (exp_q[i]) if (i < got_q.size()) chk($sformatf("ps%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.row_valid = 1'b0;
        bus.ts_done = 1'b0;
        foreach (in_row[i]) in_row[i] = 1'b1;
        foreach (wts[i]) wts[i] = 8'sd1;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        chk("rst_row_ready", 32'(bus.row_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rf_valid", 32'(bus.rf_req_valid), 32'd0);
        chk("rst_ps_valid", 32'(bus.ps_valid), 32'd0);
        chk("rst_imem_valid", 32'(bus.imem_valid), 32'd0);
        chk("rst_ts", 32'(bus.ts), 32'd1);

        run_row(-1, 1'b0, cyc);
        chk("cycles", 32'(cyc), 32'd232);

        foreach (wts[i]) wts[i] = -8'sd128;
        run_row(-1, 1'b0, cyc);
        chk("neg640", first_ps, 32'h1FF_FD80);

        foreach (wts[i]) wts[i] = 8'sd127;
        foreach (in_row[i]) in_row[i] = i == 2;
        run_row(-1, 1'b0, cyc);
        chk("bit2_win0", first_ps, 32'd127);

        stall = 1'b1;
        repeat (6) begin
            foreach (in_row[i]) in_row[i] = 1'($urandom);
            foreach (wts[i]) wts[i] = 8'($urandom);
            run_row(-1, 1'b0, cyc);
        end

        run_row(50, 1'b0, cyc);
        run_row(-1, 1'b1, cyc);

        for (int r = 0; r < RP && m_row_cnt < RP; r++) begin
            foreach (in_row[i]) in_row[i] = 1'($urandom);
            run_row(-1, 1'b0, cyc);
        end

        bus.ts_done = 1'b1;
        tick;
        bus.ts_done = 1'b0;
        m_ts = m_ts == 3 ? 3 : m_ts + 1;
        m_row_cnt = 0;
        chk("ts_idle", 32'(bus.ts), 32'(m_ts));
        run_row(-1, 1'b0, cyc);

        stall = 1'b0;
        tick;
        foreach (in_row[i]) in_row[i] = 1'($urandom);
        foreach (wts[i]) wts[i] = 8'($urandom);
        chk("rst_pre_ready", 32'(bus.row_ready), 32'd1);
        bus.row_valid = 1'b1;
        tick;
        bus.row_valid = 1'b0;
        repeat (78) tick;
        chk("rst_mid_busy", 32'(bus.busy), 32'd1);
        chk("rst_mid_ps", 32'(got_q.size()), 32'd7);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_row_ready", 32'(bus.row_ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rf_valid", 32'(bus.rf_req_valid), 32'd0);
        chk("abort_ps_valid", 32'(bus.ps_valid), 32'd0);
        chk("abort_imem_valid", 32'(bus.imem_valid), 32'd0);
        chk("abort_ts", 32'(bus.ts), 32'd1);
        cyc = imem_n;
        repeat (20) tick;
        chk("abort_no_ps", 32'(got_q.size()), 32'd7);
        chk("abort_no_imem", 32'(imem_n), 32'(cyc));
        got_q.delete();
        m_dest = 0;
        m_ts = 1;
        m_row_cnt = 0;
        run_row(-1, 1'b0, cyc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
